// File: rtl/reg_view_seg7_if.sv
// Register-read port between the debug display and the CPU register file.
//   reg_sel  : register index driven by the display stage
//   reg_data : register value for reg_sel, combinational (valid in the same cycle)
// master = display side (drives reg_sel), slave = register-file side.
interface reg_view_seg7_if;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;

    modport master (output reg_sel, input reg_data);
    modport slave  (input reg_sel, output reg_data);
endinterface

// File: rtl/reg_view_seg7.sv
// Debug register viewer. Walks x0..x31 on the CPU register-read port, captures the
// selected value into a shadow register and shows it as 8 hex digits on a multiplexed,
// active-low seven-segment display.
// Ports:
//   clk       system clock (shared with the CPU)
//   reset     synchronous active-high reset
//   auto_en   1 = advance on the dwell timer, 0 = manual stepping only
//   step      manual advance (already synchronised), rising edge advances
//   cpu       register-read port (reg_sel out, reg_data in)
//   cur_idx   register index currently shown
//   disp_an   digit enables, active-low, bit i = digit i (digit 0 = low nibble)
//   disp_seg  segments, active-low, [7]=dp, [6:0]=gfedcba
module reg_view_seg7 #(
    parameter int unsigned DIGIT_CYCLES = 100_000,
    parameter int unsigned DWELL_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   auto_en,
    input  logic                   step,
    reg_view_seg7_if.master        cpu,
    output logic [4:0]             cur_idx,
    output logic [7:0]             disp_an,
    output logic [7:0]             disp_seg
);

    localparam int unsigned DigitW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [1:0] {StSelect, StCapture, StShow} state_e;

    state_e             state_q;
    logic [4:0]         idx_q;
    logic [31:0]        shadow_q;
    logic [DwellW-1:0]  dwell_q;
    logic               step_q;
    logic [DigitW-1:0]  dcnt_q;
    logic [2:0]         digit_q;

    logic               digit_tc;
    logic               scan_wrap;
    logic               dwell_done;
    logic               advance;
    logic [3:0]         nibble;
    logic [6:0]         seg_bits;
    logic               dp_n;

    assign digit_tc   = (dcnt_q == DigitW'(DIGIT_CYCLES - 1));
    // Last cycle of digit 7: refreshing here keeps a whole scan on one value.
    assign scan_wrap  = digit_tc && (digit_q == 3'd7);
    assign dwell_done = (dwell_q == DwellW'(DWELL_CYCLES - 1));
    // A step edge and a dwell expiry in the same cycle still give one increment.
    assign advance    = (auto_en && dwell_done) || (step && !step_q);

    assign cpu.reg_sel = idx_q;
    assign cur_idx     = idx_q;

    // Selection / capture FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StSelect;
            idx_q    <= '0;
            shadow_q <= '0;
            dwell_q  <= '0;
            step_q   <= 1'b0;
        end else begin
            // Sampled every cycle so edges outside StShow are consumed, not queued.
            step_q <= step;
            case (state_q)
                StSelect: begin
                    state_q <= StCapture;
                end
                StCapture: begin
                    shadow_q <= cpu.reg_data;
                    dwell_q  <= '0;
                    state_q  <= StShow;
                end
                StShow: begin
                    if (scan_wrap) begin
                        shadow_q <= cpu.reg_data;
                    end
                    if (auto_en && !dwell_done) begin
                        dwell_q <= dwell_q + DwellW'(1);
                    end
                    if (advance) begin
                        idx_q   <= idx_q + 5'd1;
                        state_q <= StSelect;
                    end
                end
                default: begin
                    state_q <= StSelect;
                end
            endcase
        end
    end

    assign nibble = shadow_q[{digit_q, 2'b00} +: 4];
    assign dp_n   = ~(auto_en && (digit_q == 3'd7));

    always_comb begin
        seg_bits = 7'h7F;
        case (nibble)
            4'h0: seg_bits = 7'h40;
            4'h1: seg_bits = 7'h79;
            4'h2: seg_bits = 7'h24;
            4'h3: seg_bits = 7'h30;
            4'h4: seg_bits = 7'h19;
            4'h5: seg_bits = 7'h12;
            4'h6: seg_bits = 7'h02;
            4'h7: seg_bits = 7'h78;
            4'h8: seg_bits = 7'h00;
            4'h9: seg_bits = 7'h10;
            4'hA: seg_bits = 7'h08;
            4'hB: seg_bits = 7'h03;
            4'hC: seg_bits = 7'h46;
            4'hD: seg_bits = 7'h21;
            4'hE: seg_bits = 7'h06;
            4'hF: seg_bits = 7'h0E;
            default: seg_bits = 7'h7F;
        endcase
    end

    // Free-running digit scan with registered display drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q   <= '0;
            digit_q  <= '0;
            disp_an  <= 8'hFF;
            disp_seg <= 8'hFF;
        end else begin
            if (digit_tc) begin
                dcnt_q  <= '0;
                digit_q <= digit_q + 3'd1;
            end else begin
                dcnt_q <= dcnt_q + DigitW'(1);
            end
            disp_an  <= ~(8'b1 << digit_q);
            disp_seg <= {dp_n, seg_bits};
        end
    end

endmodule
